// File: rtl/flag_unit.sv
// flag_unit: grouped zero detect on the ALU result plus the NZCV flag register.
// The zero detect is one GROUP-wide NOR per group followed by a G-wide AND.
// With PIPE=1 the group partials are registered before the AND so the flag write
// lands a cycle late. Forwarding covers that cycle, so B.cond never sees stale flags.

// One group partial: high when every bit of the group is zero.
module flag_group_nor #(
  parameter int GROUP = 16
) (
  input  logic [GROUP-1:0] groupBits,
  output logic             partial
);
  assign partial = ~|groupBits;
endmodule

module flag_unit #(
  parameter int WIDTH = 64,   // must be a multiple of GROUP
  parameter int GROUP = 16,
  parameter int PIPE  = 1     // 0: write at end of issue cycle, 1: one stage before write
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             carryIn,
  input  logic             overflowIn,
  input  logic             setFlags,
  input  logic             flush,
  output logic             zeroNow,
  output logic [3:0]       flags,
  output logic [3:0]       flagsFwd,
  output logic             pending
);
  localparam int G = WIDTH / GROUP;

  logic [G-1:0] partial;
  logic [3:0]   flagsQ;

  // One NOR reducer per group, kept as separate instances so each partial
  // stays a single shallow gate ahead of the AND or the stage-1 register.
  for (genvar gi = 0; gi < G; gi++) begin : gGroup
    flag_group_nor #(.GROUP(GROUP)) uNor (
      .groupBits (result[gi*GROUP +: GROUP]),
      .partial   (partial[gi])
    );
  end

  // Zero output for CBZ/CBNZ; it never depends on setFlags or flush.
  assign zeroNow = &partial;
  assign flags   = flagsQ;

  if (PIPE == 0) begin : gNoPipe
    // Direct write: the flags become visible in the next cycle.
    always_ff @(posedge clk) begin
      if (reset)
        flagsQ <= '0;
      else if (setFlags && !flush)
        flagsQ <= {result[WIDTH-1], zeroNow, carryIn, overflowIn};
    end

    assign flagsFwd = flagsQ;
    assign pending  = 1'b0;
  end else begin : gPipe
    // Stage-1 entry. It holds the raw partials so that the AND runs after the register.
    typedef struct packed {
      logic [G-1:0] partial;
      logic         n;
      logic         c;
      logic         v;
    } s1Entry_t;

    s1Entry_t   s1;
    logic       s1Valid;
    logic [3:0] s1Flags;

    // The valid bit alone carries reset and flush. Flush drops both the held
    // entry and the one being captured this edge.
    always_ff @(posedge clk) begin
      if (reset)
        s1Valid <= 1'b0;
      else
        s1Valid <= setFlags && !flush;
    end

    // The data fields load every cycle. They only matter when s1Valid is set.
    always_ff @(posedge clk) begin
      s1.partial <= partial;
      s1.n       <= result[WIDTH-1];
      s1.c       <= carryIn;
      s1.v       <= overflowIn;
    end

    assign s1Flags = {s1.n, &s1.partial, s1.c, s1.v};

    // Retire the stage-1 entry into the architectural flags unless it is squashed.
    always_ff @(posedge clk) begin
      if (reset)
        flagsQ <= '0;
      else if (s1Valid && !flush)
        flagsQ <= s1Flags;
    end

    // The youngest valid entry wins. At most one entry is ever in flight.
    assign flagsFwd = s1Valid ? s1Flags : flagsQ;
    assign pending  = s1Valid;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised successor to the ALU zero detector. It evaluates a grouped zero-detect on the ALU result and drives a combinational zero output for CBZ/CBNZ. It also owns the architectural NZCV flag register, which is written under `setFlags` through an optional pipeline stage. Forwarded flags are provided so that B.cond never sees stale flags. It sits between the ALU and the branch/condition-check logic of the ARM datapath.

## Interface
Parameters:
- WIDTH, 64, result width in bits; must be a multiple of GROUP
- GROUP, 16, bits per NOR group; G = WIDTH/GROUP group partials
- PIPE, 1, 0 = flags written at the end of the issue cycle; 1 = one register stage between group reduction and flag write

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high
- result  input  WIDTH  ALU result
- carryIn  input  1  ALU carry-out
- overflowIn  input  1  ALU signed overflow
- setFlags  input  1  instruction writes NZCV (ADDS/SUBS)
- flush  input  1  kill pending flag write (branch mispredict/squash)
- zeroNow  output  1  combinational: 1 iff result == 0
- flags  output  4  architectural {N,Z,C,V} register
- flagsFwd  output  4  flags value after all pending writes
- pending  output  1  a stage-1 flag write is outstanding (PIPE=1 only; tied 0 when PIPE=0)

## Operation
Zero detect:
- G group partials; partial[g] = NOR of result[g*GROUP +: GROUP].
- zeroNow = AND of all partials. It is purely combinational in both PIPE modes and independent of setFlags and flush.
- N = result[WIDTH-1]; C = carryIn; V = overflowIn.

PIPE=0:
- At the edge ending cycle t, if setFlags && !flush, then flags <= {N, zeroNow, C, V}.
- flagsFwd = flags.

PIPE=1:
- Stage-1 register holds s1Valid, the G partials, N, C, and V.
- At each edge: s1Valid <= setFlags && !flush, and the data fields are captured unconditionally.
- If s1Valid && !flush at the edge, then flags <= {s1N, AND(s1 partials), s1C, s1V}.
- flagsFwd = s1Valid ? {s1N, AND(s1 partials), s1C, s1V} : flags.
- pending = s1Valid.

Flush:
- Suppresses the flag write at that edge.
- Clears s1Valid at that edge, so both the held entry and the entry being captured are dropped.
- flags retains its prior value.

Back-to-back setFlags:
- Each cycle's result is written in order. The younger entry overwrites the older one a cycle later.
- flagsFwd always reflects the youngest valid entry.

Reset:
- flags = 4'b0000, s1Valid = 0, pending = 0, flagsFwd = 4'b0000.
- Reset overrides setFlags and flush in the same cycle.

## Timing
- zeroNow: 0-cycle combinational latency. The path is one GROUP-input NOR followed by one G-input AND.
- PIPE=0: setFlags in cycle t → flags updated from cycle t+1.
- PIPE=1: setFlags in cycle t → flagsFwd and pending valid in cycle t+1; flags updated from cycle t+2.
- Flush in cycle t+1 cancels a write that was issued in cycle t.
- No stalls and no backpressure: one setFlags is accepted every cycle.
- Reset asserted mid-operation discards any stage-1 entry at the next edge.

## Test plan
- Reset, then hold reset with setFlags=1 and result=0 → flags=0000, pending=0 throughout.
- PIPE=1: result=0, carryIn=1, setFlags=1 in cycle 1 → zeroNow=1 in cycle 1; flagsFwd=0110 and pending=1 in cycle 2; flags=0110 from cycle 3.
- Back-to-back: results 0x8000_0000_0000_0000 then 0x1, with setFlags in cycles 1 and 2 (C=V=0) → flags=1000 in cycle 3, flags=0000 in cycle 4; flagsFwd=0000 in cycle 3.
- Flush: result=0 with setFlags in cycle 1, flush in cycle 2 → flags unchanged (previous value), pending=0 in cycle 3.
- Group boundaries, WIDTH=64 and GROUP=16: result values 1<<0, 1<<15, 1<<16, 1<<63 → zeroNow=0; result=0 → zeroNow=1. Repeat the checks with WIDTH=32, GROUP=8, PIPE=0, where the write lands one cycle earlier.
- setFlags=0 with result=0 for 5 cycles → zeroNow=1, flags held, pending=0.
